// File: rtl/miller_pkg.sv
// Shared types and constants for the Miller frame receiver.
// CRC constants are used only when CRC16_CHECK_EN is defined.
package miller_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HUNT = ST_HUNT,
    DATA = ST_DATA,
    DONE = ST_DONE
  } state_t;

  localparam logic [5:0] PREAMBLE_DEF = 6'b010111;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        bit_in
  );
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/miller_bit_sync.sv
// Bit clock recovery: edge-resynced period counter with a
// mid-bit sample strobe.
module miller_bit_sync #(
  parameter int BIT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_data,
  output logic strobe,
  output logic sample
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] MID  = CW'(BIT_PERIOD / 2);

  logic          d1;
  logic [CW-1:0] cnt;
  logic          edge_det;

  assign edge_det = d1 != in_data;
  assign strobe   = en && (cnt == MID) && !edge_det;
  assign sample   = d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1  <= 1'b0;
      cnt <= '0;
    end else begin
      d1 <= in_data;
      if (!en || edge_det) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/miller_frame_rx.sv
// Miller frame receiver: preamble hunt and MSB-first deserialiser.
// Define CRC16_CHECK_EN to collect and check a trailing CRC-16.
module miller_frame_rx
  import miller_pkg::*;
#(
  parameter int BIT_PERIOD = 8,
  parameter int PRE_LEN    = 6,
  parameter logic [PRE_LEN-1:0] PREAMBLE = PRE_LEN'(PREAMBLE_DEF),
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_enable,
  input  logic                  in_data,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_busy,
  output logic                  out_error
);

`ifdef CRC16_CHECK_EN
  localparam int NBITS = FRAME_BITS + 16;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam int BW = $clog2(FRAME_BITS + 16) + 1;

  state_t                state_q;
  state_t                state_d;
  logic [PRE_LEN-1:0]    pre_q;
  logic [FRAME_BITS-1:0] pay_q;
  logic [BW-1:0]         cnt_q;
  logic                  strobe;
  logic                  sample;

  logic [PRE_LEN-1:0]    pre_sh;
  logic [FRAME_BITS-1:0] pay_sh;
  logic                  last_bit;

  miller_bit_sync #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .in_data(in_data),
    .strobe (strobe),
    .sample (sample)
  );

  assign pre_sh   = {pre_q[PRE_LEN-2:0], sample};
  assign pay_sh   = {pay_q[FRAME_BITS-2:0], sample};
  assign last_bit = strobe && (cnt_q == BW'(NBITS - 1));

  assign out_busy  = (state_q == HUNT) || (state_q == DATA);
  assign out_valid = state_q == DONE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_enable) state_d = HUNT;
      HUNT: begin
        if (!in_enable) state_d = IDLE;
        else if (strobe && pre_sh == PREAMBLE) state_d = DATA;
      end
      DATA: begin
        if (!in_enable) state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      DONE: state_d = in_enable ? HUNT : IDLE;
    endcase
  end

`ifdef CRC16_CHECK_EN
  logic [15:0] crc_q;
  logic [15:0] crc_nx;

  assign crc_nx = crc16_step(crc_q, sample);
`endif

  // Frame word and status load on the final strobe so they
  // are already stable while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      pay_q    <= '0;
      cnt_q    <= '0;
      out_data <= '0;
`ifdef CRC16_CHECK_EN
      crc_q     <= '0;
      out_error <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_d == HUNT && state_q != HUNT) begin
        pre_q <= '0;
      end else if (state_q == HUNT && strobe) begin
        pre_q <= pre_sh;
      end
      if (state_q == HUNT && state_d == DATA) begin
        cnt_q <= '0;
        pay_q <= '0;
`ifdef CRC16_CHECK_EN
        crc_q <= CRC16_PRESET;
`endif
      end else if (state_q == DATA && in_enable && strobe) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q < BW'(FRAME_BITS)) pay_q <= pay_sh;
`ifdef CRC16_CHECK_EN
        crc_q <= crc_nx;
        if (last_bit) begin
          out_data  <= pay_q;
          out_error <= crc_nx != CRC16_RESIDUE;
        end
`else
        if (last_bit) out_data <= pay_sh;
`endif
      end
    end
  end

`ifndef CRC16_CHECK_EN
  assign out_error = 1'b0;
`endif

endmodule
